// File: rtl/accum_reg_bank_pkg.sv
// Shared opcodes and FSM state encoding for the accumulator register bank.
package accum_reg_bank_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_MOVE = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/accum_alu.sv
// Combinational add/subtract with borrow/overflow flag and a >= compare.
// Saturating arithmetic is selected by defining ACCUM_SAT_EN.
module accum_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] y_o,
    output logic             flag_o,
    output logic             ge_o
);

    logic [WIDTH:0] raw;

    // Returns {flag, value}; raw[WIDTH] is the borrow (sub) or carry (add).
    function automatic logic [WIDTH:0] apply_mode(input logic [WIDTH:0] r, input logic is_sub);
`ifdef ACCUM_SAT_EN
        if (!r[WIDTH]) begin
            return {1'b0, r[WIDTH-1:0]};
        end
        return is_sub ? {1'b1, {WIDTH{1'b0}}} : {1'b1, {WIDTH{1'b1}}};
`else
        return {is_sub & r[WIDTH], r[WIDTH-1:0]};
`endif
    endfunction

    always_comb begin
        raw = sub_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});
        {flag_o, y_o} = apply_mode(raw, sub_i);
    end

    assign ge_o = (a_i >= b_i);

endmodule

// File: rtl/accum_reg_bank.sv
// Accumulator register bank with single-cycle ops and a repeated-subtract DIVLOOP.
// Optional saturating ADD/SUB via the ACCUM_SAT_EN macro (see accum_alu).
module accum_reg_bank
    import accum_reg_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [SEL_W-1:0] dst_sel,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [WIDTH-1:0] register_input,
    input  logic [WIDTH-1:0] sub,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] a0out,
    output logic [WIDTH-1:0] a1out,
    output logic             busy,
    output logic             done,
    output logic             borrow,
    output logic             err
);

    localparam int DEPTH = 1 << SEL_W;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] view   [DEPTH];
    logic [DEPTH-1:0] sel_valid;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [SEL_W-1:0] dst_q, dst_d, src_q, src_d;
    logic             borrow_q, borrow_d, done_q, done_d, err_q, err_d;

    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             accept, dst_ok, src_ok;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             alu_sub, alu_flag, alu_ge;

    // Selects past NUM_REGS read as zero and are flagged invalid for writes.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
        if (gi < NUM_REGS) begin : g_reg
            assign view[gi]      = regs_q[gi];
            assign sel_valid[gi] = 1'b1;
        end else begin : g_pad
            assign view[gi]      = '0;
            assign sel_valid[gi] = 1'b0;
        end
    end

    assign op_ready = (state_q == ST_IDLE) && !RST;
    assign accept   = op_valid && op_ready;
    assign dst_ok   = sel_valid[dst_sel];
    assign src_ok   = sel_valid[src_sel];

    always_comb begin
        if (state_q == ST_RUN) begin
            alu_a   = view[dst_q];
            alu_b   = div_q;
            alu_sub = 1'b1;
        end else begin
            alu_a   = view[dst_sel];
            alu_b   = sub;
            alu_sub = (op_code == OP_SUB);
        end
    end

    accum_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .sub_i  (alu_sub),
        .y_o    (alu_y),
        .flag_o (alu_flag),
        .ge_o   (alu_ge)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        src_d    = src_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = dst_sel;
        wr_data  = alu_y;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    borrow_d = 1'b0;
                    case (op_code)
                        OP_NOP: begin
                        end
                        OP_LOAD: begin
                            wr_en   = dst_ok;
                            wr_data = register_input;
                            err_d   = !dst_ok;
                        end
                        OP_MOVE: begin
                            wr_en   = dst_ok && src_ok;
                            wr_data = view[src_sel];
                            err_d   = !(dst_ok && src_ok);
                        end
                        OP_SUB, OP_ADD: begin
                            wr_en    = dst_ok;
                            borrow_d = dst_ok && alu_flag;
                            err_d    = !dst_ok;
                        end
                        OP_DIV: begin
                            if (!dst_ok || !src_ok || sub == '0 || dst_sel == src_sel) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                                div_d   = sub;
                                cnt_d   = '0;
                                dst_d   = dst_sel;
                                src_d   = src_sel;
                            end
                        end
                        OP_CLR: begin
                            wr_en   = dst_ok;
                            wr_data = '0;
                            err_d   = !dst_ok;
                        end
                        OP_ILL: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // Either peel one more divisor off the remainder or retire the quotient.
                wr_en = 1'b1;
                if (alu_ge) begin
                    wr_idx  = dst_q;
                    wr_data = alu_y;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    wr_idx  = src_q;
                    wr_data = cnt_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        div_q <= div_d;
        cnt_q <= cnt_d;
        dst_q <= dst_d;
        src_q <= src_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = view[rd_sel];
    assign a0out   = regs_q[0];
    assign a1out   = regs_q[1];
    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign borrow  = borrow_q;
    assign err     = err_q;

endmodule

// File: tb/tb_accum_reg_bank.sv
// Bench for accum_reg_bank: directed table, DIVLOOP/reset sequences, randomized run vs. arithmetic model.
module tb_accum_reg_bank;
    import accum_reg_bank_pkg::*;

    localparam int WIDTH    = 16;
    localparam int NUM_REGS = 4;
    localparam int SEL_W    = 2;
    localparam int MASK     = (1 << WIDTH) - 1;
`ifdef ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             CLK, RST, op_valid, op_ready;
    logic [2:0]       op_code;
    logic [SEL_W-1:0] dst_sel, src_sel, rd_sel;
    logic [WIDTH-1:0] register_input, sub, rd_data, a0out, a1out;
    logic             busy, done, borrow, err;

    accum_reg_bank #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .dst_sel(dst_sel), .src_sel(src_sel), .register_input(register_input), .sub(sub),
        .rd_sel(rd_sel), .rd_data(rd_data), .a0out(a0out), .a1out(a1out),
        .busy(busy), .done(done), .borrow(borrow), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        logic [2:0] op;
        int d, s, din, sv;
        int e0, e1;
        bit eb, ee;
    } vec_t;
    vec_t tbl[11];

    int unsigned m[NUM_REGS];
    logic        mb;
    int unsigned op, d, s, din, sv, t, dividend, q, r, exp_rem;
    int          n, bad, sx;
    bit          v, eerr, ediv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input int dd, input int ss, input int di, input int sb);
        op_valid       = 1'b1;
        op_code        = o;
        dst_sel        = SEL_W'(dd);
        src_sel        = SEL_W'(ss);
        register_input = WIDTH'(di);
        sub            = WIDTH'(sb);
    endtask

    initial begin
        RST = 1'b1; op_valid = 1'b0; op_code = OP_NOP; dst_sel = '0; src_sel = '0;
        register_input = '0; sub = '0; rd_sel = '0;

        // Reset
        step();
        chk("rst_ready_low", op_ready, 0);
        step();
        RST = 1'b0;
        #1;
        chk("rst_a0", a0out, 0);
        chk("rst_a1", a1out, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, borrow, err}, 0);

        // Directed single-cycle table
        sx = SAT ? 1 : 0;
        tbl[0]  = '{OP_LOAD, 0, 0, 4620, 0, 4620, 0, 1'b0, 1'b0};
        tbl[1]  = '{OP_SUB,  0, 0, 0,    2, 4618, 0, 1'b0, 1'b0};
        tbl[2]  = '{OP_LOAD, 1, 0, 1,    0, 4618, 1, 1'b0, 1'b0};
        tbl[3]  = '{OP_SUB,  1, 0, 0,    2, 4618, (SAT ? 0 : 'hFFFF), 1'b1, 1'b0};
        tbl[4]  = '{OP_ADD,  1, 0, 0,    1, 4618, sx, 1'b0, 1'b0};
        tbl[5]  = '{OP_MOVE, 0, 1, 0,    0, sx, sx, 1'b0, 1'b0};
        tbl[6]  = '{OP_ILL,  0, 1, 99,   5, sx, sx, 1'b0, 1'b1};
        tbl[7]  = '{OP_LOAD, 1, 0, 'hFFFF, 0, sx, 'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{OP_ADD,  1, 0, 0,    2, sx, (SAT ? 'hFFFF : 1), SAT, 1'b0};
        tbl[9]  = '{OP_CLR,  1, 0, 0,    0, sx, 0, 1'b0, 1'b0};
        tbl[10] = '{OP_LOAD, 0, 0, 4620, 0, 4620, 0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].din, tbl[i].sv);
            step();
            chk($sformatf("tbl%0d_a0", i), a0out, tbl[i].e0);
            chk($sformatf("tbl%0d_a1", i), a1out, tbl[i].e1);
            chk($sformatf("tbl%0d_borrow", i), borrow, tbl[i].eb);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].ee);
        end
        op_valid = 1'b0;

        // DIVLOOP 4620/2 with a competing LOAD held on the command port
        drive(OP_DIV, 0, 1, 0, 2);
        step();
        op_code = OP_LOAD; dst_sel = 0; register_input = 16'h1234;
        n = 0; bad = 0;
        while (busy && n < 5000) begin
            n++;
            if (op_ready !== 1'b0 || done !== 1'b0) bad++;
            step();
        end
        op_valid = 1'b0;
        chk("div_busy_cycles", n, 2311);
        chk("div_ready_low_done_low", bad, 0);
        chk("div_done", done, 1);
        chk("div_a0_rem", a0out, 0);
        chk("div_a1_quot", a1out, 2310);
        step();
        chk("div_done_clears", done, 0);

        // Divide by zero
        drive(OP_LOAD, 0, 0, 77, 0); step();
        drive(OP_DIV, 0, 1, 0, 0); step();
        op_valid = 1'b0;
        chk("dz_err", err, 1);
        chk("dz_busy", busy, 0);
        chk("dz_a0", a0out, 77);
        step();
        chk("dz_err_clears", err, 0);
        chk("dz_no_done", done, 0);

        // dst == src
        drive(OP_DIV, 2, 2, 0, 3); step();
        op_valid = 1'b0;
        chk("same_sel_err", err, 1);
        chk("same_sel_busy", busy, 0);

        // Dividend below divisor: quotient 0
        drive(OP_LOAD, 0, 0, 1, 0); step();
        drive(OP_LOAD, 1, 0, 9, 0); step();
        drive(OP_DIV, 0, 1, 0, 5); step();
        op_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; step(); end
        chk("q0_cycles", n, 1);
        chk("q0_done", done, 1);
        chk("q0_a0", a0out, 1);
        chk("q0_a1", a1out, 0);

        // Reset mid-RUN
        drive(OP_LOAD, 0, 0, 4620, 0); step();
        drive(OP_LOAD, 1, 0, 55, 0); step();
        drive(OP_DIV, 0, 1, 0, 2); step();
        op_valid = 1'b0;
        repeat (100) step();
        chk("rr_still_busy", busy, 1);
        RST = 1'b1;
        step();
        chk("rr_a0", a0out, 0);
        chk("rr_a1", a1out, 0);
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_ready_in_rst", op_ready, 0);
        RST = 1'b0;
        #1;
        chk("rr_ready_after", op_ready, 1);
        step();
        chk("rr_no_done", done, 0);

        // Randomized run against the arithmetic model
        for (int i = 0; i < NUM_REGS; i++) m[i] = 0;
        mb = 1'b0;
        for (int it = 0; it < 250; it++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = $urandom_range(0, 7);
            d   = $urandom_range(0, 3);
            s   = $urandom_range(0, 3);
            din = $urandom & MASK;
            if (op == OP_DIV) sv = (m[d] >> $urandom_range(2, 6)) + $urandom_range(0, 2);
            else if ($urandom_range(0, 1) == 1) sv = $urandom_range(0, 8);
            else sv = $urandom & MASK;
            drive(3'(op), d, s, din, sv);
            op_valid = v;
            rd_sel = (op == OP_DIV) ? SEL_W'(d) : SEL_W'($urandom_range(0, 3));
            step();

            eerr = 1'b0; ediv = 1'b0;
            if (v) begin
                mb = 1'b0;
                case (op)
                    OP_LOAD: m[d] = din;
                    OP_MOVE: m[d] = m[s];
                    OP_SUB: begin
                        mb = (m[d] < sv);
                        if (mb && SAT) m[d] = 0;
                        else m[d] = (m[d] - sv) & MASK;
                    end
                    OP_ADD: begin
                        t = m[d] + sv;
                        if (SAT && t > MASK) begin m[d] = MASK; mb = 1'b1; end
                        else m[d] = t & MASK;
                    end
                    OP_DIV: if (sv == 0 || d == s) eerr = 1'b1; else ediv = 1'b1;
                    OP_CLR: m[d] = 0;
                    OP_ILL: eerr = 1'b1;
                    default: ;
                endcase
            end

            if (ediv) begin
                dividend = m[d]; q = dividend / sv; r = dividend % sv;
                n = 0; bad = 0;
                while (busy && n < 5000) begin
                    n++;
                    exp_rem = dividend - (((n - 1) < q) ? (n - 1) : q) * sv;
                    if (rd_data !== WIDTH'(exp_rem) || op_ready !== 1'b0) bad++;
                    op_valid = ($urandom_range(0, 1) == 1);
                    op_code  = 3'($urandom_range(0, 7));
                    step();
                end
                op_valid = 1'b0;
                m[d] = r; m[s] = q;
                chk($sformatf("rnd%0d_div_cycles", it), n, q + 1);
                chk($sformatf("rnd%0d_div_progress", it), bad, 0);
                chk($sformatf("rnd%0d_div_done", it), done, 1);
            end else begin
                chk($sformatf("rnd%0d_busy", it), busy, 0);
                chk($sformatf("rnd%0d_done", it), done, 0);
            end
            chk($sformatf("rnd%0d_a0", it), a0out, m[0]);
            chk($sformatf("rnd%0d_a1", it), a1out, m[1]);
            chk($sformatf("rnd%0d_rd", it), rd_data, m[rd_sel]);
            chk($sformatf("rnd%0d_borrow", it), borrow, mb);
            chk($sformatf("rnd%0d_err", it), err, eerr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
